// File: rtl/sum_stream.sv
// Streaming vector-sum accumulator: each beat is reduced by an adder tree, the beat
// sums are accumulated per frame, and one result per frame is offered on valid/ready.
module sum_stream #(
    parameter int N      = 8,
    parameter int DW     = 16,
    parameter int CW     = 8,
    parameter int SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DW-1:0]            in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW+$clog2(N)+CW-1:0] out_sum,
    output logic [CW-1:0]              out_count,
    output logic                       out_ovf
);

    localparam int SW = DW + $clog2(N);
    localparam int AW = SW + CW;
    localparam int P  = 1 << $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = '1;

    function automatic logic [SW-1:0] ext_elem(input logic [DW-1:0] e);
        if (SIGNED != 0) return {{(SW-DW){e[DW-1]}}, e};
        else             return {{(SW-DW){1'b0}}, e};
    endfunction

    // Balanced binary tree over P leaves; padding leaves are zero so non power-of-two N works.
    function automatic logic [SW-1:0] beat_sum(input logic [N*DW-1:0] data);
        logic [P*DW-1:0] padded;
        logic [SW-1:0]   node [2*P-1];
        padded = (P*DW)'(data);
        for (int i = 0; i < P; i++) node[P-1+i] = ext_elem(padded[i*DW +: DW]);
        for (int i = P-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
        return node[0];
    endfunction

    logic          en;
    logic          accept;
    logic [SW-1:0] tree_sum;

    logic          s1_vld;
    logic          s1_last;
    logic [SW-1:0] s1_sum;

    logic          first;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic [AW-1:0] sum_ext;
    logic [AW-1:0] acc_next;
    logic [CW-1:0] cnt_next;
    logic          ovf_next;
    logic          load;
    logic          close;

    // A pending, unaccepted result freezes the whole pipe.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign tree_sum = beat_sum(in_data);

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_sum  <= '0;
        end else if (en) begin
            s1_vld  <= accept;
            s1_last <= in_last;
            s1_sum  <= tree_sum;
        end
    end

    assign sum_ext = (SIGNED != 0) ? {{CW{s1_sum[SW-1]}}, s1_sum} : {{CW{1'b0}}, s1_sum};
    assign load    = en && s1_vld;
    assign close   = load && s1_last;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        acc_next = (first ? '0 : acc) + sum_ext;
        cnt_next = CW'(1);
        ovf_next = 1'b0;
        if (!first) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            ovf_next = ovf || (cnt == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            if (s1_last) begin
                first <= 1'b1;
            end else begin
                acc   <= acc_next;
                cnt   <= cnt_next;
                ovf   <= ovf_next;
                first <= 1'b0;
            end
        end
    end

    // A closing beat reloads the output even on the same edge the old result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_sum   <= acc_next;
            out_count <= cnt_next;
            out_ovf   <= ovf_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_stream.sv
// Bench for sum_stream: default, SIGNED=1 and CW=2 instances share one stimulus stream;
// results are checked against a table of known frames and a frame-level reference model.
module tb_sum_stream;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_ready;

    logic         in_ready_u, out_valid_u, out_ovf_u;
    logic [26:0]  out_sum_u;
    logic [7:0]   out_count_u;
    logic         in_ready_s, out_valid_s, out_ovf_s;
    logic [26:0]  out_sum_s;
    logic [7:0]   out_count_s;
    logic         in_ready_c, out_valid_c, out_ovf_c;
    logic [20:0]  out_sum_c;
    logic [1:0]   out_count_c;

    sum_stream #(.N(8), .DW(16), .CW(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_sum(out_sum_u), .out_count(out_count_u), .out_ovf(out_ovf_u)
    );
    sum_stream #(.N(8), .DW(16), .CW(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_sum(out_sum_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
    );
    sum_stream #(.N(8), .DW(16), .CW(2), .SIGNED(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_sum(out_sum_c), .out_count(out_count_c), .out_ovf(out_ovf_c)
    );

    typedef struct {
        logic [26:0] sum_u;
        logic [7:0]  cnt_u;
        logic        ovf_u;
        logic [26:0] sum_s;
        logic [7:0]  cnt_s;
        logic        ovf_s;
        logic [20:0] sum_c;
        logic [1:0]  cnt_c;
        logic        ovf_c;
        int          cyc;
    } res_t;

    typedef struct {
        int          nb;
        logic [15:0] fill;
        logic [15:0] step;
        logic [26:0] sum_u;
        logic [7:0]  cnt_u;
        logic [26:0] sum_s;
        logic [20:0] sum_c;
        logic [1:0]  cnt_c;
        logic        ovf_c;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    res_t exp_q [$];
    res_t obs_q [$];

    longint cur_u;
    longint cur_s;
    int     cur_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference model and result collector, evaluated mid-cycle.
    initial begin
        res_t o;
        res_t e;
        cur_u = 0;
        cur_s = 0;
        cur_n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_u = 0;
                cur_s = 0;
                cur_n = 0;
                exp_q.delete();
            end else begin
                if (out_valid_u && out_ready) begin
                    o = '{out_sum_u, out_count_u, out_ovf_u, out_sum_s, out_count_s, out_ovf_s,
                          out_sum_c, out_count_c, out_ovf_c, cyc};
                    obs_q.push_back(o);
                    check("valid_s", out_valid_s, 1'b1);
                    check("valid_c", out_valid_c, 1'b1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", out_sum_u);
                    end else begin
                        e = exp_q.pop_front();
                        check("model_sum_u", o.sum_u, e.sum_u);
                        check("model_cnt_u", o.cnt_u, e.cnt_u);
                        check("model_ovf_u", o.ovf_u, e.ovf_u);
                        check("model_sum_s", o.sum_s, e.sum_s);
                        check("model_cnt_s", o.cnt_s, e.cnt_s);
                        check("model_ovf_s", o.ovf_s, e.ovf_s);
                        check("model_sum_c", o.sum_c, e.sum_c);
                        check("model_cnt_c", o.cnt_c, e.cnt_c);
                        check("model_ovf_c", o.ovf_c, e.ovf_c);
                    end
                end
                if (in_valid && in_ready_u) begin
                    for (int k = 0; k < 8; k++) begin
                        cur_u += longint'(in_data[k*16 +: 16]);
                        cur_s += longint'($signed(in_data[k*16 +: 16]));
                    end
                    cur_n++;
                    if (in_last) begin
                        e.sum_u = cur_u[26:0];
                        e.cnt_u = (cur_n > 255) ? 8'd255 : 8'(cur_n);
                        e.ovf_u = (cur_n > 255);
                        e.sum_s = cur_s[26:0];
                        e.cnt_s = e.cnt_u;
                        e.ovf_s = e.ovf_u;
                        e.sum_c = cur_u[20:0];
                        e.cnt_c = (cur_n > 3) ? 2'd3 : 2'(cur_n);
                        e.ovf_c = (cur_n > 3);
                        e.cyc   = 0;
                        exp_q.push_back(e);
                        cur_u = 0;
                        cur_s = 0;
                        cur_n = 0;
                    end
                end
            end
        end
    end

    // Presents one beat and returns at the edge it is accepted (+1).
    task automatic send_beat(input logic [127:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready_u && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_u) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 1000 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_u"}, out_valid_u, 1'b0);
        check({tag, "_sum_u"},   out_sum_u, 27'd0);
        check({tag, "_cnt_u"},   out_count_u, 8'd0);
        check({tag, "_ovf_u"},   out_ovf_u, 1'b0);
        check({tag, "_valid_s"}, out_valid_s, 1'b0);
        check({tag, "_sum_s"},   out_sum_s, 27'd0);
        check({tag, "_valid_c"}, out_valid_c, 1'b0);
        check({tag, "_sum_c"},   out_sum_c, 21'd0);
        check({tag, "_cnt_c"},   out_count_c, 2'd0);
        check({tag, "_ovf_c"},   out_ovf_c, 1'b0);
        check({tag, "_ready_u"}, in_ready_u, 1'b1);
        check({tag, "_ready_s"}, in_ready_s, 1'b1);
        check({tag, "_ready_c"}, in_ready_c, 1'b1);
    endtask

    bit rand_done;

    initial begin
        vecs[0] = '{1, 16'hFFFF, 16'd0, 27'h7FFF8, 8'd1, 27'h7FFFFF8, 21'h7FFF8, 2'd1, 1'b0};
        vecs[1] = '{3, 16'd1,    16'd1, 27'd48,    8'd3, 27'd48,      21'd48,    2'd3, 1'b0};
        vecs[2] = '{1, 16'd5,    16'd0, 27'd40,    8'd1, 27'd40,      21'd40,    2'd1, 1'b0};
        vecs[3] = '{5, 16'd1,    16'd0, 27'd40,    8'd5, 27'd40,      21'd40,    2'd3, 1'b1};
        vecs[4] = '{2, 16'h8000, 16'd0, 27'h80000, 8'd2, 27'h7F80000, 21'h80000, 2'd2, 1'b0};
        vecs[5] = '{4, 16'h7FFF, 16'd0, 27'hFFFE0, 8'd4, 27'hFFFE0,   21'hFFFE0, 2'd3, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Known frames back-to-back with the consumer always ready.
        obs_q.delete();
        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < vecs[i].nb; j++) begin
                logic [15:0] v;
                v = vecs[i].fill + 16'(j) * vecs[i].step;
                send_beat({8{v}}, j == vecs[i].nb - 1);
            end
        end
        wait_drain();
        check("table_result_count", obs_q.size(), NV);
        for (int i = 0; i < NV && i < obs_q.size(); i++) begin
            check($sformatf("vec%0d_sum_u", i), obs_q[i].sum_u, vecs[i].sum_u);
            check($sformatf("vec%0d_cnt_u", i), obs_q[i].cnt_u, vecs[i].cnt_u);
            check($sformatf("vec%0d_ovf_u", i), obs_q[i].ovf_u, 1'b0);
            check($sformatf("vec%0d_sum_s", i), obs_q[i].sum_s, vecs[i].sum_s);
            check($sformatf("vec%0d_sum_c", i), obs_q[i].sum_c, vecs[i].sum_c);
            check($sformatf("vec%0d_cnt_c", i), obs_q[i].cnt_c, vecs[i].cnt_c);
            check($sformatf("vec%0d_ovf_c", i), obs_q[i].ovf_c, vecs[i].ovf_c);
        end
        if (obs_q.size() >= 3)
            check("b2b_consecutive_cycle", obs_q[2].cyc, obs_q[1].cyc + 1);

        // Latency: last beat accepted at edge k, out_valid seen after edge k+1.
        in_valid = 1'b1;
        in_data  = {8{16'd3}};
        in_last  = 1'b1;
        @(negedge clk);
        check("lat_in_ready", in_ready_u, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet_valid", out_valid_u, 1'b0);
        @(negedge clk);
        check("lat_valid", out_valid_u, 1'b1);
        check("lat_sum", out_sum_u, 27'd24);
        @(negedge clk);
        check("lat_consumed", out_valid_u, 1'b0);
        wait_drain();

        // Backpressure: result A pending, frame B parked in stage 1, stream blocked.
        out_ready = 1'b0;
        send_beat({8{16'h11}}, 1'b1);
        send_beat({8{16'h22}}, 1'b1);
        in_valid = 1'b1;
        in_data  = {8{16'h33}};
        in_last  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready_u, 1'b0);
            check("bp_valid_held", out_valid_u, 1'b1);
            check("bp_sum_stable", out_sum_u, 27'h88);
            check("bp_cnt_stable", out_count_u, 8'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat({8{16'h33}}, 1'b0);
        send_beat({8{16'h44}}, 1'b1);
        wait_drain();

        // Random frames, random gaps and random consumer stalls against the model.
        rand_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int nb;
                    nb = (f == 20) ? 260 : int'($urandom_range(1, 6));
                    for (int b = 0; b < nb; b++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send_beat({$urandom, $urandom, $urandom, $urandom}, b == nb - 1);
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-frame: two beats of a four-beat frame are discarded.
        send_beat({8{16'd9}}, 1'b0);
        send_beat({8{16'd9}}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat({8{16'd2}}, 1'b1);
        begin
            int t = 0;
            @(negedge clk);
            while (!out_valid_u && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        check("postrst_valid", out_valid_u, 1'b1);
        check("postrst_sum_u", out_sum_u, 27'd16);
        check("postrst_cnt_u", out_count_u, 8'd1);
        check("postrst_ovf_u", out_ovf_u, 1'b0);
        check("postrst_sum_c", out_sum_c, 21'd16);
        check("postrst_cnt_c", out_count_c, 2'd1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
